sum_accumulator: RTL and testbench



---
 rtl/sum_acc_pkg.sv | 19 +
 rtl/sum_accumulator_if.sv | 42 ++++
 rtl/sum_accumulator.sv | 97 +++++++++
 tb/tb_sum_accumulator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg: definitions shared by the sum accumulator, its interface and
// the adder stage's bench.
//   state_t   : block FSM states (ACCUM collects samples, EMIT holds a result)
//   acc_width : accumulator width that cannot wrap for BLOCK_LEN full-scale
//               sums of two DATA_W-bit operands.
package sum_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  // Each sample is at most DATA_W+1 bits; adding BLOCK_LEN of them grows
  // the value by at most ceil(log2(BLOCK_LEN)) bits.
  function automatic int acc_width(input int data_w, input int block_len);
    return data_w + 1 + $clog2(block_len);
  endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: input and output valid/ready streams of the sum
// accumulator, plus its FSM state for observation.
//   in_valid/in_ready/in_sum : adder results (DATA_W+1 bits, unsigned)
//   flush                    : close the current partial block early
//   out_valid/out_ready      : block result handshake
//   out_total/out_count      : block total (ACC_W) and sample count (CNT_W)
//   dbg_state                : current FSM state
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both 1; a producer holding valid=1 keeps its data
// stable until that edge, and never withdraws valid before the transfer.
// modport master: the upstream/downstream environment; modport slave: the
// accumulator itself.
interface sum_accumulator_if
  import sum_acc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BLOCK_LEN = 4
);
  localparam int ACC_W = acc_width(DATA_W, BLOCK_LEN);
  localparam int CNT_W = $clog2(BLOCK_LEN + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W:0]   in_sum;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_total;
  logic [CNT_W-1:0]  out_count;
  state_t            dbg_state;

  modport master (
    output in_valid, in_sum, flush, out_ready,
    input  in_ready, out_valid, out_total, out_count, dbg_state
  );

  modport slave (
    input  in_valid, in_sum, flush, out_ready,
    output in_ready, out_valid, out_total, out_count, dbg_state
  );

endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums BLOCK_LEN consecutive adder results (or fewer when
// flushed) and presents each block total with its sample count.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : sum_accumulator_if.slave (input stream, flush, output stream,
//          debug state)
// All outputs are registered except in_ready, which decodes from state.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BLOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  sum_accumulator_if.slave bus
);

  localparam int ACC_W = acc_width(DATA_W, BLOCK_LEN);
  localparam int CNT_W = $clog2(BLOCK_LEN + 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  // Held low by reset and set on the first edge after release, so in_ready
  // stays low during reset and for the cycle that reset is released in.
  logic             ready_en_q;

  logic             accept;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt_inc;

  assign bus.in_ready  = ready_en_q && (state_q == ACCUM);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_total = total_q;
  assign bus.out_count = out_count_q;
  assign bus.dbg_state = state_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign acc_sum = acc_q + ACC_W'(bus.in_sum);
  assign cnt_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    total_d     = total_q;
    out_count_d = out_count_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d   = acc_sum;
          count_d = cnt_inc;
        end
        // Close the block on the sample that fills it, or on a flush that
        // has at least one sample (possibly the one arriving this cycle).
        if ((accept && (cnt_inc == CNT_W'(BLOCK_LEN))) ||
            (bus.flush && ((count_q != '0) || accept))) begin
          state_d     = EMIT;
          total_d     = acc_d;
          out_count_d = count_d;
        end
      end
      EMIT: begin
        // Flush and new samples are ignored here; in_ready is low.
        if (bus.out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          count_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      total_q     <= '0;
      out_count_q <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      total_q     <= total_d;
      out_count_q <= out_count_d;
      ready_en_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed scenarios followed by random traffic for
// sum_accumulator, checked against a block-level model (list of samples in
// the open block, queue of results waiting to be taken).
module tb_sum_accumulator;
  import sum_acc_pkg::*;

  localparam int DATA_W    = 8;
  localparam int BLOCK_LEN = 4;
  localparam int ACC_W     = acc_width(DATA_W, BLOCK_LEN);
  localparam int CNT_W     = $clog2(BLOCK_LEN + 1);
  localparam int W         = ACC_W + CNT_W;

  logic clk;
  logic rst;

  sum_accumulator_if #(.DATA_W(DATA_W), .BLOCK_LEN(BLOCK_LEN)) bus ();

  sum_accumulator #(.DATA_W(DATA_W), .BLOCK_LEN(BLOCK_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int             n_cmp;
  int             n_err;
  int             blk[$];        // samples of the open block
  logic [W-1:0]   exp_q[$];      // {total, count} results not yet taken
  bit             ready_en;      // false until the first edge after reset

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Closes the open block into an expected result.
  task automatic close_block();
    int sum;
    sum = 0;
    foreach (blk[i]) sum += blk[i];
    exp_q.push_back({ACC_W'(sum), CNT_W'(blk.size())});
    blk.delete();
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive at the falling edge, check the DUT outputs against
  // the model, advance the model by what the rising edge will do.
  task automatic step(input logic v, input logic [DATA_W:0] s,
                      input logic f, input logic r);
    logic [W-1:0] head;
    bit           pending;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_sum    = s;
    bus.flush     = f;
    bus.out_ready = r;
    #1;
    pending = (exp_q.size() > 0);
    check_val("in_ready", {31'd0, bus.in_ready}, {31'd0, ready_en && !pending});
    check_val("out_valid", {31'd0, bus.out_valid}, {31'd0, pending});
    if (pending) begin
      head = exp_q[0];
      check_val("out_total", 32'(bus.out_total), 32'(head[W-1:CNT_W]));
      check_val("out_count", 32'(bus.out_count), 32'(head[CNT_W-1:0]));
      if (r) void'(exp_q.pop_front());
    end else if (ready_en) begin
      if (v) blk.push_back(int'(s));
      if (blk.size() == BLOCK_LEN || (f && blk.size() > 0)) close_block();
    end
    ready_en = 1'b1;
    @(posedge clk);
  endtask

  // Looks at the registered outputs just after the last rising edge.
  task automatic check_now(input string tag, input int total, input int count);
    #1;
    check_val({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check_val({tag, "_total"}, 32'(bus.out_total), 32'(total));
    check_val({tag, "_count"}, 32'(bus.out_count), 32'(count));
  endtask

  // Asynchronous reset asserted between edges, released just after a
  // rising edge so the following cycle must still show in_ready=0.
  task automatic reset_dut();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("rst_out_total", 32'(bus.out_total), 32'd0);
    check_val("rst_out_count", 32'(bus.out_count), 32'd0);
    blk.delete();
    exp_q.delete();
    ready_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp         = 0;
    n_err         = 0;
    ready_en      = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values.
    #1;
    check_val("init_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_val("init_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("init_out_total", 32'(bus.out_total), 32'd0);
    check_val("init_out_count", 32'(bus.out_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);  // in_ready still 0 this cycle
    step(1'b0, '0, 1'b0, 1'b0);

    // Full block, back to back.
    step(1'b1, 9'd10, 1'b0, 1'b1);
    step(1'b1, 9'd20, 1'b0, 1'b1);
    step(1'b1, 9'd30, 1'b0, 1'b1);
    step(1'b1, 9'd40, 1'b0, 1'b1);
    check_now("full", 100, 4);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Largest sums: no wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 9'd510, 1'b0, 1'b0);
    check_now("max", 2040, 4);
    step(1'b0, '0, 1'b0, 1'b1);

    // Flush together with a sample.
    step(1'b1, 9'd7, 1'b0, 1'b0);
    step(1'b1, 9'd8, 1'b0, 1'b0);
    step(1'b1, 9'd9, 1'b1, 1'b0);
    check_now("flush", 24, 3);
    step(1'b0, '0, 1'b0, 1'b1);

    // Backpressure with in_valid held high.
    for (int i = 0; i < 4; i++) step(1'b1, 9'd1, 1'b0, 1'b0);
    check_now("bp", 4, 4);
    for (int i = 0; i < 5; i++) step(1'b1, 9'd99, 1'b0, 1'b0);
    step(1'b1, 9'd99, 1'b0, 1'b1);
    step(1'b1, 9'd2, 1'b0, 1'b0);
    step(1'b1, 9'd3, 1'b1, 1'b0);
    check_now("bp_next", 5, 2);
    step(1'b0, '0, 1'b0, 1'b1);

    // Empty flush, then flush while a result waits.
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 9'd5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // out_ready during ACCUM, then reset in the middle of a block.
    step(1'b1, 9'd5, 1'b0, 1'b1);
    step(1'b1, 9'd6, 1'b0, 1'b1);
    reset_dut();
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 9'(i), 1'b0, 1'b0);
    check_now("after_rst", 10, 4);
    step(1'b0, '0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           9'($urandom_range(0, 510)),
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
    end
    // Drain any waiting result.
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
